// File: rtl/simple_sched_pkg.sv
// simple_sched_pkg
//   Shared types and constants for the simple_sched round-robin scheduler.
//   - sched_state_t : scheduler FSM states (IDLE / EXEC / RESP)
//   - DEF_N_REQ / DEF_IN_SIZE : default requester count and operand width
//   - STAT_W : width of the optional per-requester grant counters
//   - out_size() : result width derived from the operand width
package simple_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_IN_SIZE = 4;
    localparam int STAT_W      = 16;

    // 2*a - b needs one extra bit over the operand width.
    function automatic int out_size(input int in_size);
        return in_size + 1;
    endfunction

endpackage

// File: rtl/simple_sched_if.sv
// simple_sched_if
//   Request/response bundle between client blocks and simple_sched.
//   master : client side (drives req_valid/req_a/req_b/rsp_ready)
//   slave  : scheduler side (drives req_ready/rsp_valid/rsp_id/rsp_data)
//   req_a/req_b pack requester i at bits [i*IN_SIZE +: IN_SIZE].
interface simple_sched_if
    import simple_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int IN_SIZE = DEF_IN_SIZE
);
    localparam int ID_W     = $clog2(N_REQ);
    localparam int OUT_SIZE = out_size(IN_SIZE);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*IN_SIZE-1:0] req_a;
    logic [N_REQ*IN_SIZE-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [OUT_SIZE-1:0]      rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/simple_rr_pick.sv
// simple_rr_pick
//   Combinational round-robin picker. Searches req starting at ptr and
//   wrapping modulo N; the first set bit wins.
//   Ports:
//     req        : N-bit request vector
//     ptr        : search start index (must be < N)
//     found      : at least one request is set
//     gnt_idx    : index of the winner (0 when nothing found)
//     gnt_onehot : one-hot winner (all zero when nothing found)
module simple_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot
);
    // Walk the offsets from the farthest to the nearest so that the
    // nearest requester (lowest offset from ptr) is written last and wins.
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : gen_onehot
        assign gnt_onehot[gi] = found && (gnt_idx == ID_W'(gi));
    end

endmodule

// File: rtl/simple_sched.sv
// simple_sched
//   Round-robin scheduler sharing one (2*a - b) datapath between N_REQ
//   requesters. One transaction at a time: IDLE grants and latches
//   operands, EXEC computes, RESP holds the result until rsp_ready.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : simple_sched_if.slave (request/response handshakes)
//   Optional (SIMPLE_SCHED_STATS_EN defined):
//     stat_sel   : requester index to read
//     stat_cnt   : saturating 16-bit grant count of requester stat_sel
module simple_sched
    import simple_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int IN_SIZE = DEF_IN_SIZE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    simple_sched_if.slave              bus
`ifdef SIMPLE_SCHED_STATS_EN
    ,
    input  logic [$clog2(N_REQ)-1:0]   stat_sel,
    output logic [STAT_W-1:0]          stat_cnt
`endif
);
    localparam int OUT_SIZE = out_size(IN_SIZE);
    localparam int ID_W     = $clog2(N_REQ);

    sched_state_t        state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     gnt_reg;
    logic [IN_SIZE-1:0]  a_reg, b_reg;
    logic [OUT_SIZE-1:0] res_reg;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [N_REQ-1:0]    pick_onehot;
    logic                accept;
    logic                rsp_fire;
    logic [N_REQ-1:0]    ready_vec;

    logic [IN_SIZE-1:0]  a_lane [N_REQ];
    logic [IN_SIZE-1:0]  b_lane [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_lane
        assign a_lane[gi] = bus.req_a[gi*IN_SIZE +: IN_SIZE];
        assign b_lane[gi] = bus.req_b[gi*IN_SIZE +: IN_SIZE];
    end

    simple_rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req        (bus.req_valid),
        .ptr        (ptr_reg),
        .found      (pick_found),
        .gnt_idx    (pick_idx),
        .gnt_onehot (pick_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        ready_vec  = '0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    accept     = 1'b1;
                    ready_vec  = pick_onehot;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The state register already sits in IDLE while reset is held, so the
    // ready bits are masked by rst_n to keep them low during reset.
    assign bus.req_ready = rst_n ? ready_vec : '0;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_id    = (state_reg == RESP) ? gnt_reg : '0;
    assign bus.rsp_data  = (state_reg == RESP) ? res_reg : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
            gnt_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
        end else begin
            if (accept) begin
                a_reg   <= a_lane[pick_idx];
                b_reg   <= b_lane[pick_idx];
                gnt_reg <= pick_idx;
            end
            if (state_reg == EXEC) begin
                // {a,0} is 2*a in OUT_SIZE bits; the subtraction wraps
                // naturally as two's complement.
                res_reg <= {a_reg, 1'b0} - {1'b0, b_reg};
            end
            if (rsp_fire) begin
                ptr_reg <= (gnt_reg == ID_W'(N_REQ - 1)) ? '0 : gnt_reg + 1'b1;
            end
        end
    end

`ifdef SIMPLE_SCHED_STATS_EN
    logic [STAT_W-1:0] cnt_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_stat
        logic [STAT_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (accept && (pick_idx == ID_W'(gi)) && (cnt_reg != {STAT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign cnt_arr[gi] = cnt_reg;
    end

    // Non-power-of-two N_REQ leaves unused select codes; those read 0.
    assign stat_cnt = (int'(stat_sel) < N_REQ) ? cnt_arr[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_simple_sched.sv
// tb_simple_sched
//   Directed and randomized stimulus for simple_sched (N_REQ=4, IN_SIZE=4)
//   checked against a transaction-level reference model: round-robin
//   winner search from a pointer, result = (2a-b) mod 32 visible two
//   cycles after the accept edge, pointer = winner+1 after response.
module tb_simple_sched;
    localparam int N  = 4;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    simple_sched_if #(.N_REQ(N), .IN_SIZE(W)) bus ();

`ifdef SIMPLE_SCHED_STATS_EN
    logic [1:0]  stat_sel = '0;
    logic [15:0] stat_cnt;
`endif

    simple_sched #(.N_REQ(N), .IN_SIZE(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef SIMPLE_SCHED_STATS_EN
        ,
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    bit       m_busy = 0;
    int       m_age  = 0;
    int       m_ptr  = 0;
    int       m_gnt  = 0;
    logic [4:0] m_data = '0;

    // Last observed DUT values (for directed checks)
    logic [3:0] last_ready;
    logic       last_rv;
    logic [1:0] last_id;
    logic [4:0] last_data;

    int obs_grants[$];
    int obs_gcyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_age  = 0;
        m_ptr  = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // cross the rising edge, advance the model.
    task automatic cycle(input logic [3:0] v, input logic [15:0] a,
                         input logic [15:0] b, input logic rr);
        int win;
        logic [3:0] exp_ready;
        bit exp_rv;
        int tmp;
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = rr;
        #1;
        win = -1;
        exp_ready = '0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (v[idx] && win < 0) win = idx;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_rv = m_busy && (m_age >= 2);

        last_ready = bus.req_ready;
        last_rv    = bus.rsp_valid;
        last_id    = bus.rsp_id;
        last_data  = bus.rsp_data;
        for (int i = 0; i < N; i++) begin
            if (last_ready[i]) begin
                obs_grants.push_back(i);
                obs_gcyc.push_back(cyc);
            end
        end

        chk("req_ready", 32'(last_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(last_rv), 32'(exp_rv));
        if (exp_rv) begin
            chk("rsp_id", 32'(last_id), 32'(m_gnt));
            chk("rsp_data", 32'(last_data), 32'(m_data));
        end
        $display("cyc=%0d valid=%b ready=%b rsp_valid=%b id=%0d data=%0d rsp_ready=%b",
                 cyc, v, last_ready, last_rv, last_id, last_data, rr);

        @(posedge clk);
        #1;
        cyc++;
        if (!m_busy && win >= 0) begin
            m_busy = 1;
            m_age  = 1;
            m_gnt  = win;
            tmp    = 2 * int'(a[win*W +: W]) - int'(b[win*W +: W]);
            m_data = 5'(tmp);
        end else if (m_busy) begin
            if (exp_rv && rr) begin
                m_busy = 0;
                m_ptr  = (m_gnt + 1) % N;
            end else begin
                m_age++;
            end
        end
    endtask

    // A single requester alone on the bus, rsp_ready high throughout.
    task automatic run_one(input int idx, input logic [3:0] a, input logic [3:0] b,
                           input logic [4:0] exp_data);
        logic [15:0] pa;
        logic [15:0] pb;
        logic [3:0]  v;
        pa = '0; pb = '0; v = '0;
        pa[idx*W +: W] = a;
        pb[idx*W +: W] = b;
        v[idx] = 1'b1;
        cycle(v, pa, pb, 1'b1);
        chk("single_ready", 32'(last_ready), 32'(v));
        cycle('0, pa, pb, 1'b1);
        chk("exec_no_rsp", 32'(last_rv), 32'd0);
        cycle('0, pa, pb, 1'b1);
        chk("resp_valid_t2", 32'(last_rv), 32'd1);
        chk("resp_id_const", 32'(last_id), 32'(idx));
        chk("resp_data_const", 32'(last_data), 32'(exp_data));
    endtask

    initial begin
        logic [3:0]  pend;
        logic [15:0] ra, rb;
        logic [15:0] fa, fb;
        int expo[5];

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset values, with requests pending during reset
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        bus.req_valid = '0;
        #1;
        rst_n = 1'b1;
        model_reset();

        // Single request: 2*5-3 = 7
        run_one(0, 4'd5, 4'd3, 5'd7);
        // Wrap: 0-1 -> 31, 2*15-0 = 30
        run_one(1, 4'd0, 4'd1, 5'b11111);
        run_one(3, 4'd15, 4'd0, 5'd30);

        // Fairness: all valid; ptr is 0 after requester 3 finished
        fa = 16'h4321;
        fb = 16'h3210;
        obs_grants.delete();
        obs_gcyc.delete();
        for (int i = 0; i < 13; i++) cycle(4'b1111, fa, fb, 1'b1);
        expo = '{0, 1, 2, 3, 0};
        chk("rr_count", 32'(obs_grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_grants.size(); i++) begin
            chk("rr_order", 32'(obs_grants[i]), 32'(expo[i]));
            if (i > 0) chk("rr_spacing", 32'(obs_gcyc[i] - obs_gcyc[i-1]), 32'd3);
        end
        // Drain the last transaction (grant 0 taken on the final cycle)
        cycle('0, fa, fb, 1'b1);
        cycle('0, fa, fb, 1'b1);

        // Backpressure on requester 2 (ptr is 1): 2*6-1 = 11
        fa = 16'h0600;
        fb = 16'h0100;
        cycle(4'b0100, fa, fb, 1'b0);
        chk("bp_grant", 32'(last_ready), 32'b0100);
        cycle(4'b1011, fa, fb, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1011, fa, fb, 1'b0);
            chk("bp_hold_valid", 32'(last_rv), 32'd1);
            chk("bp_hold_id", 32'(last_id), 32'd2);
            chk("bp_hold_data", 32'(last_data), 32'd11);
        end
        cycle(4'b1011, fa, fb, 1'b1);
        cycle(4'b1011, fa, fb, 1'b1);
        chk("bp_next_from_3", 32'(last_ready), 32'b1000);
        cycle('0, fa, fb, 1'b1);
        cycle('0, fa, fb, 1'b1);

        // Reset mid-EXEC: move ptr to 2, accept requester 2, then abort
        run_one(1, 4'd2, 4'd2, 5'd2);
        cycle(4'b0100, 16'h0300, 16'h0100, 1'b1);
        bus.req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        cycle('0, '0, '0, 1'b1);
        cycle('0, '0, '0, 1'b1);
        cycle(4'b1111, fa, fb, 1'b1);
        chk("post_rst_grant0", 32'(last_ready), 32'b0001);
        cycle('0, fa, fb, 1'b1);
        cycle('0, fa, fb, 1'b1);

        // Randomized traffic with the hold-until-ready rule
        pend = '0;
        ra = '0;
        rb = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i*W +: W] = 4'($urandom);
                    rb[i*W +: W] = 4'($urandom);
                end
            end
            cycle(pend, ra, rb, ($urandom_range(0, 9) < 7));
            pend = pend & ~last_ready;
        end
        for (int i = 0; i < 8; i++) cycle('0, ra, rb, 1'b1);

`ifdef SIMPLE_SCHED_STATS_EN
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run_one(2, 4'd1, 4'd1, 5'd1);
        for (int s = 0; s < N; s++) begin
            stat_sel = 2'(s);
            #1;
            chk("stat_cnt", 32'(stat_cnt), (s == 2) ? 32'd3 : 32'd0);
        end
        force dut.gen_stat[2].cnt_reg = 16'hFFFF;
        #1;
        release dut.gen_stat[2].cnt_reg;
        stat_sel = 2'd2;
        #1;
        chk("stat_forced", 32'(stat_cnt), 32'hFFFF);
        run_one(2, 4'd1, 4'd1, 5'd1);
        chk("stat_saturate", 32'(stat_cnt), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simple_sched.md
Name: simple_sched

Overview:
- Round-robin scheduler that shares one `2*a - b` datapath between N_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester, registers its operands, computes the OUT_SIZE-bit result and returns it tagged with the requester ID.
- Sits in front of the arithmetic datapath, between client blocks and the shared compute resource.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IN_SIZE, 4, operand width per requester.
- OUT_SIZE (localparam), IN_SIZE+1, result width.
- ID_W (localparam), $clog2(N_REQ), requester-ID width.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit set.
- req_a  input  N_REQ*IN_SIZE  operand a; requester i occupies bits [i*IN_SIZE +: IN_SIZE].
- req_b  input  N_REQ*IN_SIZE  operand b; same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_id  output  ID_W  index of the requester that produced the result.
- rsp_data  output  OUT_SIZE  result.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - ptr = 0.
  - Operand, grant and result registers = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, req_ready = 0.
- IDLE:
  - Winner g = first i with req_valid[i] = 1, searching from ptr upward and wrapping modulo N_REQ.
  - req_ready[g] = 1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: latch a_r, b_r and gnt = g, then go to EXEC.
  - No valid requester: stay in IDLE, all ready bits 0.
- EXEC (one cycle):
  - res_r <= (2*a_r - b_r) mod 2^OUT_SIZE, two's complement, no saturation.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id = gnt; rsp_data = res_r; all three held stable until rsp_ready = 1.
  - On the edge where rsp_ready = 1: ptr <= (gnt+1) mod N_REQ, go to IDLE.
  - req_ready stays 0 throughout EXEC and RESP.
- Latency and throughput:
  - Accept edge at cycle t gives rsp_valid = 1 from cycle t+2.
  - Maximum throughput is one transaction per 3 cycles when rsp_ready is held high.
- Requester rules:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - Dropping req_valid before grant is legal; that requester is simply not selected.
- Fairness: a requester that continuously asserts valid is granted within N_REQ transactions.
- Single requester: it is granted every time, whatever the value of ptr.
- rsp_ready asserted outside RESP is ignored.
- rst_n low in any state, including mid-EXEC or mid-RESP, aborts the transaction immediately: all registers and outputs return to reset values and no response is issued.

Optional Feature:
- Macro: SIMPLE_SCHED_STATS_EN.
- With the macro defined:
  - Extra ports: stat_sel input ID_W; stat_cnt output 16.
  - One 16-bit counter per requester, incremented on that requester's accept edge and saturating at 16'hFFFF.
  - stat_cnt = counter[stat_sel], combinational.
  - Counters reset to 0 on rst_n.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package simple_sched_pkg:
  - State enum type sched_state_t (IDLE/EXEC/RESP).
  - Default constants for IN_SIZE and N_REQ.
  - Function computing OUT_SIZE from IN_SIZE.
  - STAT_W = 16.
- Sub-module simple_rr_pick:
  - Purely combinational, parameter N.
  - Inputs: req[N] and ptr.
  - Outputs: found, plus gnt_idx and gnt_onehot.
  - Reused by other arbiters in the design.

Test Plan:
- Single request: reset, req_valid = 4'b0001, a0 = 5, b0 = 3, rsp_ready = 1 → req_ready = 0001 at accept cycle t; rsp_valid at t+2 with rsp_id = 0, rsp_data = 5'd7.
- Arithmetic wrap: a = 0, b = 1 → rsp_data = 5'b11111. a = 15, b = 0 → rsp_data = 5'd30.
- Round-robin fairness: all four valid continuously, rsp_ready = 1 → grant order 0,1,2,3,0; each transaction takes 3 cycles; no ready bit is asserted outside IDLE.
- Backpressure: rsp_ready = 0 for 5 cycles in RESP → rsp_valid, rsp_id and rsp_data held stable, no new grant; releases on the rsp_ready edge, then ptr advances.
- Reset mid-operation: assert rst_n = 0 asynchronously during EXEC → rsp_valid = 0 and req_ready = 0 immediately; after release the next grant starts from requester 0.
- Stats (SIMPLE_SCHED_STATS_EN defined): 3 grants to requester 2 → stat_sel = 2 reads stat_cnt = 3, other indices read 0; forced to 16'hFFFF, one more grant keeps it at 16'hFFFF.
